pwm_capture: RTL

//  Register-mapped PWM input decoder, the receive-side counterpart of the pwm generator peripheral.

---
 rtl/pwm_capture.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: register-mapped PWM input decoder.
// Synchronises pwm_i and measures its period and high time in prescaled ticks.
// Optional build macro: PWM_CAP_IRQ_EN adds the irq_o port and the CTRL.ie bit.
// Ports:
//   clk_i    - clock, all logic on the rising edge
//   rst_ni   - asynchronous active-low reset
//   write    - one-cycle register write strobe
//   addr_i   - byte register address
//   wdata_i  - write data
//   rdata_o  - read data, combinational from addr_i
//   irq_o    - level interrupt (PWM_CAP_IRQ_EN builds only)
//   pwm_i    - asynchronous PWM input
// Register map: 0x00 CTRL, 0x04 DIVISOR, 0x08 PERIOD, 0x0C HIGH, 0x10 STATUS.
module pwm_capture #(
    parameter int unsigned CNT_W = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        write,
    input  logic [7:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
`ifdef PWM_CAP_IRQ_EN
    output logic        irq_o,
`endif
    input  logic        pwm_i
);

    localparam int unsigned DIV_W = 16;
    localparam int unsigned SUM_W = CNT_W + 1;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_DIV    = 8'h04;
    localparam logic [7:0] ADDR_PERIOD = 8'h08;
    localparam logic [7:0] ADDR_HIGH   = 8'h0C;
    localparam logic [7:0] ADDR_STATUS = 8'h10;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_RISE = 2'd1;
    localparam logic [1:0] S_HIGH      = 2'd2;
    localparam logic [1:0] S_LOW       = 2'd3;

    logic             sync1_q, sync2_q, hist_q;
    logic             rise_c, fall_c;
    logic [DIV_W-1:0] div_reg_q, div_q, div_eff_c, psc_q;
    logic             tick_c;
    logic             en_q, cont_q, ie_rd_c;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, hsh_q, hsh_d;
    logic [CNT_W-1:0] period_q, high_q;
    logic             valid_q, ovf_q;
    logic             cap_c, ovf_set_c, en_clr_c, busy_c;
    logic [SUM_W-1:0] sum_c;
    logic             wr_ctrl_c, wr_div_c, wr_stat_c;
    logic             unused_wdata;

    assign unused_wdata = ^wdata_i[31:16];

    assign wr_ctrl_c = write && (addr_i == ADDR_CTRL);
    assign wr_div_c  = write && (addr_i == ADDR_DIV);
    assign wr_stat_c = write && (addr_i == ADDR_STATUS);

    // Two-flop synchroniser plus history flop for edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= pwm_i;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign rise_c = sync2_q && !hist_q;
    assign fall_c = !sync2_q && hist_q;

    // Prescaler, phase-aligned to each rising edge; divisor 0 behaves as 1
    assign div_eff_c = (div_q == 16'd0) ? 16'd1 : div_q;
    assign tick_c    = (psc_q == (div_eff_c - 16'd1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            psc_q <= '0;
            div_q <= '0;
        end else begin
            if (rise_c) begin
                psc_q <= '0;
                div_q <= div_reg_q;
            end else if (tick_c) begin
                psc_q <= '0;
            end else begin
                psc_q <= psc_q + 16'd1;
            end
        end
    end

    assign sum_c = {1'b0, cnt_q} + SUM_W'(tick_c);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state and measurement datapath control
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hsh_d     = hsh_q;
        cap_c     = 1'b0;
        ovf_set_c = 1'b0;
        en_clr_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en_q) state_d = S_WAIT_RISE;
            end
            S_WAIT_RISE: begin
                if (!en_q) begin
                    state_d = S_IDLE;
                end else if (rise_c) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end
            end
            S_HIGH: begin
                if (!en_q) begin
                    state_d = S_IDLE;
                end else if (sum_c[CNT_W]) begin
                    ovf_set_c = 1'b1;
                    state_d   = S_WAIT_RISE;
                end else begin
                    cnt_d = sum_c[CNT_W-1:0];
                    if (fall_c) begin
                        hsh_d   = sum_c[CNT_W-1:0];
                        state_d = S_LOW;
                    end
                end
            end
            S_LOW: begin
                if (!en_q) begin
                    state_d = S_IDLE;
                end else if (sum_c[CNT_W]) begin
                    ovf_set_c = 1'b1;
                    state_d   = S_WAIT_RISE;
                end else begin
                    cnt_d = sum_c[CNT_W-1:0];
                    if (rise_c) begin
                        cap_c = 1'b1;
                        if (cont_q) begin
                            state_d = S_HIGH;
                            cnt_d   = '0;
                        end else begin
                            state_d  = S_IDLE;
                            en_clr_c = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_c = (state_q == S_HIGH) || (state_q == S_LOW);

    // Counters and results; PERIOD/HIGH load together on capture
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            hsh_q    <= '0;
            period_q <= '0;
            high_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            hsh_q <= hsh_d;
            if (cap_c) begin
                period_q <= sum_c[CNT_W-1:0];
                high_q   <= hsh_q;
            end
        end
    end

    // Software registers; a software CTRL write overrides the one-shot clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q      <= 1'b0;
            cont_q    <= 1'b0;
            div_reg_q <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (wr_ctrl_c) begin
                en_q   <= wdata_i[0];
                cont_q <= wdata_i[1];
            end else if (en_clr_c) begin
                en_q <= 1'b0;
            end
            if (wr_div_c) div_reg_q <= wdata_i[DIV_W-1:0];
            // Hardware set wins over a same-cycle W1C
            valid_q <= cap_c     || (valid_q && !(wr_stat_c && wdata_i[0]));
            ovf_q   <= ovf_set_c || (ovf_q   && !(wr_stat_c && wdata_i[1]));
        end
    end

`ifdef PWM_CAP_IRQ_EN
    logic ie_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ie_q  <= 1'b0;
            irq_o <= 1'b0;
        end else begin
            if (wr_ctrl_c) ie_q <= wdata_i[3];
            irq_o <= ie_q && (valid_q || ovf_q);
        end
    end

    assign ie_rd_c = ie_q;
`else
    assign ie_rd_c = 1'b0;
`endif

    // Read mux
    always_comb begin
        rdata_o = 32'd0;
        case (addr_i)
            ADDR_CTRL:   rdata_o = {28'd0, ie_rd_c, 1'b0, cont_q, en_q};
            ADDR_DIV:    rdata_o = {16'd0, div_reg_q};
            ADDR_PERIOD: rdata_o = 32'(period_q);
            ADDR_HIGH:   rdata_o = 32'(high_q);
            ADDR_STATUS: rdata_o = {29'd0, busy_c, ovf_q, valid_q};
            default:     rdata_o = 32'd0;
        endcase
    end

endmodule
